// File: rtl/div_ctrl.sv
// div_ctrl: 32-bit restoring radix-2 divider for DIV/DIVU with pipeline annul.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor short-circuits through DIVZERO.
module div_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        annul,
    output logic        stall_req,
    output logic        busy,
    output logic        ready,
    output logic        whilo_out,
    output logic [31:0] lo_out,
    output logic [31:0] hi_out
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 6;
    localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

`ifdef DIV_ZERO_FAST_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2,
        DIVZERO = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
`endif

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dvd_r;      // dividend shifting out, quotient shifting in
    logic [DW-1:0] dvs_r;
    logic [DW-1:0] rem_r;
    logic          q_neg_r;
    logic          r_neg_r;

    logic [DW:0]   part;
    logic [DW:0]   diff;
    logic [DW-1:0] q_next;
    logic [DW-1:0] r_next;
    logic [DW-1:0] abs1;
    logic [DW-1:0] abs2;
    logic          launch;
    logic          zero_div;

    // One restoring step: borrow out of bit 32 means the trial subtract failed
    always_comb begin
        part   = {rem_r, dvd_r[DW-1]};
        diff   = part - {1'b0, dvs_r};
        q_next = {dvd_r[DW-2:0], ~diff[DW]};
        r_next = diff[DW] ? part[DW-1:0] : diff[DW-1:0];
    end

    always_comb begin
        abs1     = (signed_div && src1[DW-1]) ? -src1 : src1;
        abs2     = (signed_div && src2[DW-1]) ? -src2 : src2;
        launch   = (state == IDLE) && start && !annul;
`ifdef DIV_ZERO_FAST_EN
        zero_div = (src2 == '0);
`else
        zero_div = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and control outputs; annul wins over start and completion
    always_comb begin
        next_state = state;
        stall_req  = 1'b0;
        busy       = 1'b0;
        ready      = 1'b0;
        whilo_out  = 1'b0;
        case (state)
            IDLE: begin
                stall_req = rstn && start;
                if (launch) begin
`ifdef DIV_ZERO_FAST_EN
                    next_state = zero_div ? DIVZERO : BUSY;
`else
                    next_state = BUSY;
`endif
                end
            end
`ifdef DIV_ZERO_FAST_EN
            DIVZERO: begin
                stall_req  = 1'b1;
                busy       = 1'b1;
                next_state = annul ? IDLE : DONE;
            end
`endif
            BUSY: begin
                stall_req = 1'b1;
                busy      = 1'b1;
                if (annul) begin
                    next_state = IDLE;
                end else if (cnt == LAST_CNT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                ready      = 1'b1;
                whilo_out  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, and result capture on DONE entry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            dvd_r   <= '0;
            dvs_r   <= '0;
            rem_r   <= '0;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
            lo_out  <= '0;
            hi_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        cnt     <= '0;
                        rem_r   <= '0;
                        dvs_r   <= abs2;
                        dvd_r   <= zero_div ? src1 : abs1;
                        q_neg_r <= signed_div && (src1[DW-1] ^ src2[DW-1]);
                        r_neg_r <= signed_div && src1[DW-1];
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                DIVZERO: begin
                    if (!annul) begin
                        lo_out <= '1;
                        hi_out <= dvd_r;
                    end
                end
`endif
                BUSY: begin
                    dvd_r <= q_next;
                    rem_r <= r_next;
                    cnt   <= cnt + CW'(1);
                    if ((cnt == LAST_CNT) && !annul) begin
                        lo_out <= q_neg_r ? -q_next : q_next;
                        hi_out <= r_neg_r ? -r_next : r_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed checks of div_ctrl latency, results, annul and reset.
// Define DIV_ZERO_FAST_EN for both bench and RTL to exercise the fast zero path.
module tb_div_ctrl;
    logic        clk;
    logic        rstn;
    logic        start;
    logic        signed_div;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        annul;
    logic        stall_req;
    logic        busy;
    logic        ready;
    logic        whilo_out;
    logic [31:0] lo_out;
    logic [31:0] hi_out;

    int total = 0;
    int bad   = 0;

    div_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .signed_div (signed_div),
        .src1       (src1),
        .src2       (src2),
        .annul      (annul),
        .stall_req  (stall_req),
        .busy       (busy),
        .ready      (ready),
        .whilo_out  (whilo_out),
        .lo_out     (lo_out),
        .hi_out     (hi_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Launch one divide, scramble operands after acceptance, wait for ready
    task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input int exp_lat);
        int cyc;
        bit got_rdy;
        bit stall_ok;
        @(negedge clk);
        signed_div = sd;
        src1       = a;
        src2       = b;
        annul      = 1'b0;
        start      = 1'b1;
        #1;
        chk({tag, "_stall_t0"}, 32'(stall_req), 32'd1);
        cyc      = 0;
        got_rdy  = 1'b0;
        stall_ok = 1'b1;
        while (cyc < 40 && !got_rdy) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                src1       = 32'hDEAD_BEEF;
                src2       = 32'd3;
                signed_div = ~sd;
            end
            if (ready) got_rdy = 1'b1;
            else if (!stall_req) stall_ok = 1'b0;
        end
        start = 1'b0;
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_stall_busy"}, 32'(stall_ok), 32'd1);
        chk({tag, "_stall_done"}, 32'(stall_req), 32'd0);
        chk({tag, "_whilo"}, 32'(whilo_out), 32'd1);
        chk({tag, "_lo"}, lo_out, exp_lo);
        chk({tag, "_hi"}, hi_out, exp_hi);
        @(posedge clk);
        #1;
        chk({tag, "_rdy_pulse"}, 32'(ready), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Launch 100/7 and stop at cycle n (sampled just after the nth edge)
    task automatic launch_and_wait(input int n);
        @(negedge clk);
        signed_div = 1'b0;
        src1       = 32'd100;
        src2       = 32'd7;
        annul      = 1'b0;
        start      = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        int rdy_seen;
        int zero_lat;
        rstn       = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        src1       = '0;
        src2       = '0;
        annul      = 1'b0;
`ifdef DIV_ZERO_FAST_EN
        zero_lat = 2;
`else
        zero_lat = 33;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_whilo", 32'(whilo_out), 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
        run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 33);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, zero_lat);

        // Annul at T10: back to IDLE, results untouched, then a clean restart
        launch_and_wait(10);
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("annul_busy", 32'(busy), 32'd0);
        chk("annul_ready", 32'(ready), 32'd0);
        chk("annul_lo", lo_out, 32'hFFFF_FFFF);
        chk("annul_hi", hi_out, 32'd5);
        annul = 1'b0;
        @(posedge clk);
        run_div("after_annul", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

        // Annul on the final BUSY cycle beats completion
        launch_and_wait(32);
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("annul_last_ready", 32'(ready), 32'd0);
        chk("annul_last_busy", 32'(busy), 32'd0);
        chk("annul_last_lo", lo_out, 32'd14);
        annul = 1'b0;

        // start together with annul in IDLE must not launch
        @(negedge clk);
        src1  = 32'd9;
        src2  = 32'd3;
        start = 1'b1;
        annul = 1'b1;
        @(posedge clk);
        #1;
        chk("start_annul_busy", 32'(busy), 32'd0);
        start = 1'b0;
        annul = 1'b0;

        // Asynchronous reset mid-divide
        launch_and_wait(15);
        rstn = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall_req), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_lo", lo_out, 32'd0);
        chk("mid_rst_hi", hi_out, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready) rdy_seen++;
        end
        chk("mid_rst_no_ready", 32'(rdy_seen), 32'd0);
        run_div("after_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
